// File: rtl/store_buffer.sv
// Store buffer for the M stage: formats stores, flags AdES, and queues legal stores
// in a FIFO that drains over m_valid/m_ready. Optional STORE_COALESCE_EN merges same-word stores into the tail.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        exc_ov,
    output logic        exc_AdES,
    output logic        st_stall,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_byteen,
    output logic        drained
);
    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_SW   = 2'd1;
    localparam logic [1:0] OP_SH   = 2'd2;
    localparam logic [1:0] OP_SB   = 2'd3;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    function automatic logic [31:0] fmt_data(input logic [1:0] op, input logic [31:0] d);
        case (op)
            OP_SH:   return {2{d[15:0]}};
            OP_SB:   return {4{d[7:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] fmt_byteen(input logic [1:0] op, input logic [1:0] a);
        case (op)
            OP_SW:   return 4'b1111;
            OP_SH:   return a[1] ? 4'b1100 : 4'b0011;
            OP_SB:   return 4'b0001 << a;
            default: return 4'b0000;
        endcase
    endfunction

    logic [29:0]    addr_r   [DEPTH];
    logic [31:0]    data_r   [DEPTH];
    logic [3:0]     byteen_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r;
    logic [PTR_W:0]   count_r;

    logic [15:0] a16_s;
    logic        in_range_s, dev_s, timer_cnt_s, misalign_s;
    logic        store_req_s, full_s, empty_s, pop_s, push_s, merge_s;
    logic [31:0] new_data_s;
    logic [3:0]  new_be_s;
    logic        unused_s;

    assign a16_s      = st_addr[15:0];
    assign new_data_s = fmt_data(st_op, st_data);
    assign new_be_s   = fmt_byteen(st_op, st_addr[1:0]);
    assign unused_s   = ^ld_addr[1:0];

    // Address-error classification on the low 16 address bits.
    always_comb begin
        in_range_s  = (a16_s <= 16'h2FFF)
                    || (a16_s >= 16'h7F00 && a16_s <= 16'h7F0B)
                    || (a16_s >= 16'h7F10 && a16_s <= 16'h7F1B)
                    || (a16_s >= 16'h7F20 && a16_s <= 16'h7F23);
        dev_s       = (a16_s >= 16'h7F00);
        timer_cnt_s = (a16_s >= 16'h7F08 && a16_s <= 16'h7F0B)
                    || (a16_s >= 16'h7F18 && a16_s <= 16'h7F1B);
        misalign_s  = ((st_op == OP_SW) && (st_addr[1:0] != 2'b00))
                    || ((st_op == OP_SH) && st_addr[0]);
        if (st_valid && (st_op != OP_NONE)) begin
            exc_AdES = exc_ov || misalign_s || !in_range_s
                     || ((st_op != OP_SW) && dev_s)
                     || ((st_op == OP_SW) && timer_cnt_s);
        end else begin
            exc_AdES = 1'b0;
        end
    end

    assign store_req_s = st_valid && (st_op != OP_NONE) && !exc_AdES;
    assign full_s      = (count_r == FULL_CNT);
    assign empty_s     = (count_r == '0);
    assign pop_s       = !empty_s && m_ready;

`ifdef STORE_COALESCE_EN
    logic [PTR_W-1:0] tail_ptr_s;
    assign tail_ptr_s = wr_ptr_r - PTR_W'(1);
    // Merge only into a RAM-address tail that is not leaving the buffer this cycle.
    assign merge_s = store_req_s && valid_r[tail_ptr_s]
                  && (addr_r[tail_ptr_s] == st_addr[31:2])
                  && (a16_s < 16'h3000)
                  && !(pop_s && (tail_ptr_s == rd_ptr_r));
`else
    assign merge_s = 1'b0;
`endif

    assign push_s   = store_req_s && !merge_s && !full_s;
    assign st_stall = store_req_s && !merge_s && full_s;
    assign drained  = empty_s;

    // FIFO pointers, occupancy and entry storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i]   <= 30'd0;
                data_r[i]   <= 32'd0;
                byteen_r[i] <= 4'd0;
            end
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s) begin
                valid_r[wr_ptr_r]  <= 1'b1;
                addr_r[wr_ptr_r]   <= st_addr[31:2];
                data_r[wr_ptr_r]   <= new_data_s;
                byteen_r[wr_ptr_r] <= new_be_s;
                wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
            end
`ifdef STORE_COALESCE_EN
            if (merge_s) begin
                byteen_r[tail_ptr_s] <= byteen_r[tail_ptr_s] | new_be_s;
                for (int b = 0; b < 4; b++) begin
                    if (new_be_s[b]) begin
                        data_r[tail_ptr_s][8*b +: 8] <= new_data_s[8*b +: 8];
                    end
                end
            end
`endif
        end
    end

    // Head presentation; zeros when the buffer is empty.
    always_comb begin
        m_valid = !empty_s;
        if (!empty_s) begin
            m_addr   = {addr_r[rd_ptr_r], 2'b00};
            m_wdata  = data_r[rd_ptr_r];
            m_byteen = byteen_r[rd_ptr_r];
        end else begin
            m_addr   = 32'd0;
            m_wdata  = 32'd0;
            m_byteen = 4'd0;
        end
    end

    // Load-hit detection against every pending entry, head included.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ld_req && valid_r[i] && (addr_r[i] == ld_addr[31:2])) begin
                ld_hit = 1'b1;
            end else begin
                ld_hit = ld_hit;
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer; expectations hand-derived from the store formatting,
// AdES rules and FIFO ordering. Coalescing expectations follow STORE_COALESCE_EN.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic [1:0]  st_op = 2'd0;
    logic [31:0] st_addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    logic        exc_ov = 1'b0;
    logic        exc_AdES, st_stall, ld_hit, m_valid, drained;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = 32'd0;
    logic        m_ready = 1'b0;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_byteen;

    int n_checks = 0;
    int n_fail   = 0;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data), .exc_ov(exc_ov), .exc_AdES(exc_AdES),
        .st_stall(st_stall), .ld_req(ld_req), .ld_addr(ld_addr), .ld_hit(ld_hit),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_byteen(m_byteen), .drained(drained)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic v, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] d, input logic ov);
        st_valid = v; st_op = op; st_addr = a; st_data = d; exc_ov = ov;
        #1;
    endtask

    logic [1:0]  bad_op   [5] = '{2'd2, 2'd1, 2'd3, 2'd1, 2'd1};
    logic [31:0] bad_addr [5] = '{32'h0003, 32'h7F08, 32'h7F00, 32'h3000, 32'h0000};
    logic        bad_ov   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        tick(); tick();
        reset = 1'b0;
        #1;
        check_eq("rst_drained", 32'(drained), 32'd1);
        check_eq("rst_mvalid", 32'(m_valid), 32'd0);
        check_eq("rst_maddr", m_addr, 32'd0);
        check_eq("rst_wdata", m_wdata, 32'd0);
        check_eq("rst_byteen", 32'(m_byteen), 32'd0);
        check_eq("rst_stall", 32'(st_stall), 32'd0);
        check_eq("rst_ldhit", 32'(ld_hit), 32'd0);

        // sb to 0x5
        m_ready = 1'b1;
        drive_st(1'b1, 2'd3, 32'h0005, 32'h0000_00AB, 1'b0);
        check_eq("sb_ades", 32'(exc_AdES), 32'd0);
        tick();
        drive_st(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        check_eq("sb_mvalid", 32'(m_valid), 32'd1);
        check_eq("sb_maddr", m_addr, 32'h0000_0004);
        check_eq("sb_wdata", m_wdata, 32'hABAB_ABAB);
        check_eq("sb_byteen", 32'(m_byteen), 32'b0010);
        check_eq("sb_notdrained", 32'(drained), 32'd0);
        tick();
        check_eq("sb_drained", 32'(drained), 32'd1);

        // address errors: none are enqueued
        for (int i = 0; i < 5; i++) begin
            drive_st(1'b1, bad_op[i], bad_addr[i], 32'h1234_5678, bad_ov[i]);
            check_eq($sformatf("ades_%0d", i), 32'(exc_AdES), 32'd1);
            check_eq($sformatf("ades_nostall_%0d", i), 32'(st_stall), 32'd0);
            tick();
            check_eq($sformatf("ades_empty_%0d", i), 32'(drained), 32'd1);
        end
        drive_st(1'b0, 2'd2, 32'h0003, 32'd0, 1'b0);
        check_eq("ades_gated", 32'(exc_AdES), 32'd0);
        m_ready = 1'b0;
        drive_st(1'b1, 2'd1, 32'h7F04, 32'hCAFE_F00D, 1'b0);
        check_eq("dev_ok_ades", 32'(exc_AdES), 32'd0);
        tick();
        drive_st(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        check_eq("dev_ok_maddr", m_addr, 32'h0000_7F04);
        check_eq("dev_ok_byteen", 32'(m_byteen), 32'hF);
        m_ready = 1'b1;
        tick();
        check_eq("dev_ok_drained", 32'(drained), 32'd1);

        // fill, stall, FIFO order
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_st(1'b1, 2'd1, 32'(4 * i), 32'h100 + 32'(i), 1'b0);
            check_eq($sformatf("fill_nostall_%0d", i), 32'(st_stall), 32'd0);
            tick();
        end
        drive_st(1'b1, 2'd1, 32'h0010, 32'hD5, 1'b0);
        check_eq("full_stall", 32'(st_stall), 32'd1);
        m_ready = 1'b1;
        #1;
        check_eq("full_stall_pop", 32'(st_stall), 32'd1);
        check_eq("order_0", m_addr, 32'h0);
        tick();
        check_eq("stall_clear", 32'(st_stall), 32'd0);
        check_eq("order_1", m_addr, 32'h4);
        tick();
        drive_st(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        check_eq("order_2", m_addr, 32'h8);
        check_eq("order_2_data", m_wdata, 32'h102);
        tick();
        check_eq("order_3", m_addr, 32'hC);
        tick();
        check_eq("order_4", m_addr, 32'h10);
        check_eq("order_4_data", m_wdata, 32'hD5);
        tick();
        check_eq("order_drained", 32'(drained), 32'd1);

        // full buffer with simultaneous pop and blocked store
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_st(1'b1, 2'd1, 32'h20 + 32'(4 * i), 32'h200 + 32'(i), 1'b0);
            tick();
        end
        drive_st(1'b1, 2'd1, 32'h0030, 32'h204, 1'b0);
        m_ready = 1'b1;
        #1;
        check_eq("pp_stall", 32'(st_stall), 32'd1);
        check_eq("pp_head0", m_addr, 32'h20);
        tick();
        check_eq("pp_head1", m_addr, 32'h24);
        tick();
        drive_st(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 2; i < 5; i++) begin
            check_eq($sformatf("pp_head%0d", i), m_addr, 32'h20 + 32'(4 * i));
            check_eq($sformatf("pp_data%0d", i), m_wdata, 32'h200 + 32'(i));
            tick();
        end
        check_eq("pp_drained", 32'(drained), 32'd1);

        // load hit against pending stores
        m_ready = 1'b0;
        drive_st(1'b1, 2'd1, 32'h0010, 32'h55, 1'b0);
        tick();
        drive_st(1'b1, 2'd2, 32'h0042, 32'h0000_1234, 1'b0);
        tick();
        drive_st(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        ld_req = 1'b1; ld_addr = 32'h0012; #1;
        check_eq("ldhit_same_word", 32'(ld_hit), 32'd1);
        ld_addr = 32'h0014; #1;
        check_eq("ldhit_next_word", 32'(ld_hit), 32'd0);
        ld_addr = 32'h0040; #1;
        check_eq("ldhit_second", 32'(ld_hit), 32'd1);
        ld_req = 1'b0; #1;
        check_eq("ldhit_noreq", 32'(ld_hit), 32'd0);
        ld_req = 1'b1; ld_addr = 32'h0010;
        m_ready = 1'b1; #1;
        check_eq("ldhit_popcycle", 32'(ld_hit), 32'd1);
        tick();
        check_eq("ldhit_after_pop", 32'(ld_hit), 32'd0);
        check_eq("sh_wdata", m_wdata, 32'h1234_1234);
        check_eq("sh_byteen", 32'(m_byteen), 32'b1100);
        ld_req = 1'b0;
        tick();

        // same-word byte stores
        m_ready = 1'b0;
        drive_st(1'b1, 2'd3, 32'h0020, 32'h11, 1'b0);
        tick();
        drive_st(1'b1, 2'd3, 32'h0021, 32'h22, 1'b0);
        tick();
        drive_st(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        check_eq("co_addr", m_addr, 32'h20);
`ifdef STORE_COALESCE_EN
        check_eq("co_byteen", 32'(m_byteen), 32'b0011);
        check_eq("co_wdata_lo", 32'(m_wdata[15:0]), 32'h2211);
        m_ready = 1'b1;
        tick();
        check_eq("co_one_entry", 32'(drained), 32'd1);
`else
        check_eq("co_byteen", 32'(m_byteen), 32'b0001);
        check_eq("co_wdata", m_wdata, 32'h1111_1111);
        m_ready = 1'b1;
        tick();
        check_eq("co_second_entry", 32'(m_valid), 32'd1);
        check_eq("co_second_byteen", 32'(m_byteen), 32'b0010);
        check_eq("co_second_wdata", m_wdata, 32'h2222_2222);
        tick();
        check_eq("co_drained", 32'(drained), 32'd1);
`endif

        // reset mid-operation discards entries
        m_ready = 1'b0;
        drive_st(1'b1, 2'd1, 32'h0100, 32'h77, 1'b0);
        tick();
        drive_st(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
        check_eq("midrst_pending", 32'(m_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_eq("midrst_mvalid", 32'(m_valid), 32'd0);
        check_eq("midrst_drained", 32'(drained), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Store-side counterpart of the M-stage load path.
- Accepts store requests from the M stage and generates byte enables and lane-replicated write data.
- Detects AdES (address error on store).
- Queues legal stores in a small FIFO that drains to the data bus (DM / bridge) over a valid/ready handshake.
- Reports pipeline stall when full, and flags loads that hit a pending store.

Parameters:
DEPTH, 4, number of buffer entries; power of two, >= 2
PTR_W, 2, log2(DEPTH); pointer width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
st_valid  input  1  M-stage instruction valid (not bubble, not flushed)
st_op  input  2  0 none, 1 sw, 2 sh, 3 sb
st_addr  input  32  effective byte address
st_data  input  32  rt register value
exc_ov  input  1  overflow in address computation
exc_AdES  output  1  store address exception (combinational)
st_stall  output  1  stall M stage; store cannot be accepted
ld_req  input  1  M-stage load present
ld_addr  input  32  load byte address
ld_hit  output  1  pending entry targets the same word as ld_addr
m_valid  output  1  head entry presented on bus
m_ready  input  1  bus accepts head this cycle
m_addr  output  32  head word address, bits [1:0] = 0
m_wdata  output  32  head write data
m_byteen  output  4  head byte enables
drained  output  1  buffer empty

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset: count=0, rd_ptr=wr_ptr=0, all entry valid bits 0, m_valid=0. m_addr, m_wdata and m_byteen read 0 whenever empty. drained=1. st_stall=0 and ld_hit=0 until inputs assert.
- Data and byte-enable formatting (stored per entry):
  - sw: data as-is, byteen 1111.
  - sh: {2{data[15:0]}}, byteen 1100 if addr[1] else 0011.
  - sb: {4{data[7:0]}}, byteen = 0001 << addr[1:0].
- AdES, using addr[15:0] for range checks. Asserted when st_valid, st_op!=0, and any of:
  - exc_ov;
  - misaligned: sw with addr[1:0]!=0, or sh with addr[0]=1;
  - out of range: outside 0x0000-0x2FFF, 0x7F00-0x7F0B, 0x7F10-0x7F1B, 0x7F20-0x7F23;
  - non-sw to any address >= 0x7F00;
  - sw to a timer count register (0x7F08-0x7F0B, 0x7F10+8 to 0x7F1B).
- exc_AdES is forced 0 when st_op=0 or st_valid=0.
- Enqueue: when st_valid, st_op!=0, !exc_AdES and count<DEPTH, write entry at wr_ptr on the next edge and increment count. A faulting store is never enqueued.
- st_stall = st_valid & st_op!=0 & !exc_AdES & (count==DEPTH).
  - Uses the registered count only; no combinational path from m_ready.
  - A simultaneous pop does not release the stall that cycle.
- Dequeue: m_valid = (count!=0); outputs reflect the entry at rd_ptr. When m_valid & m_ready, pop on the edge.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Bus order is strictly FIFO.
- Head outputs stay stable while m_valid & !m_ready.
- ld_hit = ld_req & OR over valid entries of (entry addr[31:2] == ld_addr[31:2]).
  - Includes the head, including during its pop cycle.
  - Excludes the store being enqueued the same cycle (no same-cycle load+store in one M stage).
- drained = (count==0). Used by the CP0 path to order ERET and interrupts.
- Reset mid-operation: all pending entries are discarded; m_valid drops on the reset edge.
- Exceptions and flushes upstream deassert st_valid. Already-queued entries still drain.

Optional Feature:
- Macro: STORE_COALESCE_EN.
- Defined:
  - An accepted store whose addr[31:2] equals the tail entry's (entry at wr_ptr-1, valid) merges into it instead of allocating: new bytes overwrite per byteen, and byteen ORs.
  - Merging is allowed only if the tail is not the head being popped this cycle, and the address is < 0x3000 (no merging into device addresses).
  - A merge proceeds even when count==DEPTH; st_stall is 0 in that case.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset, then sb to 0x0005 with st_data=0x000000AB, m_ready=1 -> next cycle m_valid=1, m_addr=0x4, m_wdata=0xABABABAB, m_byteen=0010; drained returns to 1 after the pop.
- sh to 0x0003, sw to 0x7F08, sb to 0x7F00, sw to 0x3000, exc_ov=1 with sw to 0x0 -> exc_AdES=1 for each, count stays 0. sw to 0x7F04 -> accepted.
- m_ready=0, 4 sw to 0x0,0x4,0x8,0xC -> count=4, fifth sw sees st_stall=1. Raise m_ready -> bus order 0x0,0x4,0x8,0xC, stall clears the cycle after the first pop.
- Full buffer with push+pop in the same cycle -> stall stays asserted that cycle, count stays 4, no entry lost. Pointer wrap verified over 10 stores.
- Pending sw to 0x0010 with m_ready=0, ld_req with ld_addr=0x0012 -> ld_hit=1. ld_addr=0x0014 -> ld_hit=0.
- STORE_COALESCE_EN: sb 0x20=0x11 then sb 0x21=0x22 with m_ready=0 -> one entry, byteen 0011, wdata[15:0]=0x2211. Without the macro -> two entries.
